// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - two-requester round-robin front end for a fixed-latency AES core
module aes_req_arbiter #(
    parameter int unsigned LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    input  logic         rsp_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       cnt_done;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Gated by rst_n so neither requester sees a handshake while reset is held.
    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign cnt_done   = (cnt == LAST_CNT);

    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (cnt_done)  state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // core_in is only written on accept so the core input is frozen for the whole flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 8'd0;
            core_in    <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            core_in    <= grant ? req1_data : req0_data;
            rsp_id     <= grant;
            last_grant <= grant;
            cnt        <= 8'd0;
        end else if (state == RUN) begin
            cnt <= cnt + 8'd1;
            if (cnt_done) begin
                rsp_data <= core_out;
            end
        end
    end

endmodule
